// File: rtl/round_pkg.sv
// Shared types and helpers for the round controller: phase encoding, BCD timer value,
// round-limit calculation and BCD countdown step.
package round_pkg;

  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    READY     = 3'd1,
    PLAY      = 3'd2,
    CAUGHT    = 3'd3,
    LEVEL_UP  = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  localparam int MIN_ROUND_SECS = 10;

  function automatic bcd_t to_bcd(input logic [6:0] v);
    bcd_t b;
    b.tens = 4'(v / 7'd10);
    b.ones = 4'(v % 7'd10);
    return b;
  endfunction

  // Each difficulty step takes 5 s off the round, never below the floor.
  function automatic bcd_t round_limit(input int round_secs, input logic [1:0] difficulty);
    int lim;
    lim = round_secs - 5 * int'(difficulty);
    if (lim < MIN_ROUND_SECS) lim = MIN_ROUND_SECS;
    return to_bcd(7'(lim));
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t b);
    bcd_t r;
    r = b;
    if (b.ones != 4'd0) begin
      r.ones = b.ones - 4'd1;
    end else if (b.tens != 4'd0) begin
      r.tens = b.tens - 4'd1;
      r.ones = 4'd9;
    end
    return r;
  endfunction

endpackage

// File: rtl/round_controller_if.sv
// Signal bundle between the round controller and the top level / game datapath.
// slave = controller side, master = top level / datapath side.
interface round_controller_if;
  import round_pkg::*;

  logic       FrameSync;
  logic       Continue;
  logic [1:0] Difficulty;
  logic       PlayerCaught;
  logic       PlayerEscaped;

  state_t     State;
  logic [1:0] Map;
  logic       GameEnable;
  logic       RoundReset;
  logic       ShowText;
  logic       Win;
  logic [3:0] SecsTens;
  logic [3:0] SecsOnes;
  logic [3:0] Lives;
  logic [1:0] Level;

  modport slave (
    input  FrameSync, Continue, Difficulty, PlayerCaught, PlayerEscaped,
    output State, Map, GameEnable, RoundReset, ShowText, Win,
           SecsTens, SecsOnes, Lives, Level
  );

  modport master (
    output FrameSync, Continue, Difficulty, PlayerCaught, PlayerEscaped,
    input  State, Map, GameEnable, RoundReset, ShowText, Win,
           SecsTens, SecsOnes, Lives, Level
  );

endinterface

// File: rtl/round_controller_edge_sync.sv
// Two-flop synchronizer plus one-cycle pulse on the selected edge of an asynchronous pin.
// The pulse is sampled by the 3rd Clk edge after the pin edge; no backpressure.
module edge_sync #(
  parameter logic FALL_EDGE = 1'b0,
  parameter logic IDLE_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  // [1:0] are the metastability stages, [2] is the previous synchronized value.
  logic [2:0] sync_q, sync_d;

  assign sync_d = {sync_q[1:0], din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {3{IDLE_VAL}};
    else        sync_q <= sync_d;
  end

  assign pulse = FALL_EDGE ? (sync_q[2] & ~sync_q[1]) : (sync_q[1] & ~sync_q[2]);

endmodule

// File: rtl/round_controller.sv
// Robber-game session sequencer: title, countdown, play, caught, level-up and game-over phases.
// Pin events act 3 Clk after their edge; all outputs registered; event driven, no backpressure.
module round_controller
  import round_pkg::*;
#(
  parameter int FRAMES_PER_SEC = 60,
  parameter int ROUND_SECS     = 30,
  parameter int READY_SECS     = 3,
  parameter int HOLD_SECS      = 2,
  parameter int START_LIVES    = 3,
  parameter int NUM_LEVELS     = 4
) (
  input logic              Clk,
  input logic              Reset_n,
  round_controller_if.slave bus
);

  localparam int              FC_W       = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FC_W-1:0] FC_LAST    = FC_W'(FRAMES_PER_SEC - 1);
  localparam bcd_t            READY_BCD  = to_bcd(7'(READY_SECS));
  localparam bcd_t            RESET_SECS = round_limit(ROUND_SECS, 2'b00);
  localparam bcd_t            SECS_ONE   = to_bcd(7'd1);
  localparam logic [3:0]      HOLD_CNT   = 4'(HOLD_SECS);
  localparam logic [3:0]      LIVES_INIT = 4'(START_LIVES);
  localparam logic [1:0]      LAST_LEVEL = 2'(NUM_LEVELS - 1);

  // Reset asserts asynchronously, releases two Clk edges later.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  assign rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  logic frame_pulse, cont_pulse;

  edge_sync #(.FALL_EDGE(1'b1), .IDLE_VAL(1'b1)) u_frame_sync (
    .clk(Clk), .rst_n(rst_n), .din(bus.FrameSync), .pulse(frame_pulse)
  );

  edge_sync #(.FALL_EDGE(1'b0), .IDLE_VAL(1'b0)) u_cont_sync (
    .clk(Clk), .rst_n(rst_n), .din(bus.Continue), .pulse(cont_pulse)
  );

  state_t          state_q, state_d;
  bcd_t            secs_q, secs_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]      hold_q, hold_d;
  logic [3:0]      lives_q, lives_d;
  logic [1:0]      level_q, level_d;
  logic            win_q, win_d;
  logic            game_enable_q, game_enable_d;
  logic            show_text_q, show_text_d;
  logic            round_reset_q, round_reset_d;
  logic            sec_pulse;

  always_comb begin
    state_d     = state_q;
    secs_d      = secs_q;
    frame_cnt_d = frame_cnt_q;
    hold_d      = hold_q;
    lives_d     = lives_q;
    level_d     = level_q;
    win_d       = win_q;
    sec_pulse   = 1'b0;

    if (frame_pulse && state_q != TITLE && state_q != GAME_OVER) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d = '0;
        sec_pulse   = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end

    case (state_q)
      TITLE: begin
        // Preview the round limit the current Difficulty would give.
        secs_d = round_limit(ROUND_SECS, bus.Difficulty);
        if (cont_pulse) begin
          state_d = READY;
          lives_d = LIVES_INIT;
          level_d = 2'd0;
          win_d   = 1'b0;
        end
      end
      READY: begin
        if (sec_pulse) begin
          if (secs_q == '0) state_d = PLAY;
          else              secs_d  = bcd_dec(secs_q);
        end
      end
      PLAY: begin
        if (sec_pulse) secs_d = bcd_dec(secs_q);
        if (bus.PlayerCaught || (sec_pulse && secs_q == SECS_ONE)) begin
          state_d = CAUGHT;
          lives_d = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
        end else if (bus.PlayerEscaped) begin
          state_d = LEVEL_UP;
        end
      end
      CAUGHT: begin
        if (sec_pulse) begin
          if (hold_q > 4'd1) hold_d  = hold_q - 4'd1;
          else               state_d = (lives_q != 4'd0) ? READY : GAME_OVER;
        end
      end
      LEVEL_UP: begin
        if (sec_pulse) begin
          if (hold_q > 4'd1) begin
            hold_d = hold_q - 4'd1;
          end else if (level_q == LAST_LEVEL) begin
            state_d = GAME_OVER;
            win_d   = 1'b1;
          end else begin
            level_d = level_q + 2'd1;
            state_d = READY;
          end
        end
      end
      GAME_OVER: begin
        if (cont_pulse) state_d = TITLE;
      end
      default: state_d = TITLE;
    endcase

    // Every phase starts with a fresh frame count; Difficulty is sampled only here for PLAY.
    if (state_d != state_q) begin
      frame_cnt_d = '0;
      case (state_d)
        READY:            secs_d = READY_BCD;
        PLAY:             secs_d = round_limit(ROUND_SECS, bus.Difficulty);
        CAUGHT, LEVEL_UP: hold_d = HOLD_CNT;
        default:          ;
      endcase
    end
  end

  assign game_enable_d = (state_d == PLAY);
  assign show_text_d   = (state_d != PLAY);
  assign round_reset_d = (state_d == READY) && (state_q != READY);

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= TITLE;
      secs_q        <= RESET_SECS;
      frame_cnt_q   <= '0;
      hold_q        <= 4'd0;
      lives_q       <= LIVES_INIT;
      level_q       <= 2'd0;
      win_q         <= 1'b0;
      game_enable_q <= 1'b0;
      show_text_q   <= 1'b1;
      round_reset_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      secs_q        <= secs_d;
      frame_cnt_q   <= frame_cnt_d;
      hold_q        <= hold_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      win_q         <= win_d;
      game_enable_q <= game_enable_d;
      show_text_q   <= show_text_d;
      round_reset_q <= round_reset_d;
    end
  end

  assign bus.State      = state_q;
  assign bus.Map        = level_q;
  assign bus.Level      = level_q;
  assign bus.GameEnable = game_enable_q;
  assign bus.RoundReset = round_reset_q;
  assign bus.ShowText   = show_text_q;
  assign bus.Win        = win_q;
  assign bus.SecsTens   = secs_q.tens;
  assign bus.SecsOnes   = secs_q.ones;
  assign bus.Lives      = lives_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed plus randomized bench for round_controller, checked against a phase-level game model.
module tb_round_controller;
  import round_pkg::*;

  localparam int FPS    = 4;
  localparam int RSECS  = 12;
  localparam int RDY    = 2;
  localparam int HOLD   = 1;
  localparam int LIVES0 = 2;
  localparam int NLVL   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  round_controller_if bus ();

  round_controller #(
    .FRAMES_PER_SEC(FPS), .ROUND_SECS(RSECS), .READY_SECS(RDY),
    .HOLD_SECS(HOLD), .START_LIVES(LIVES0), .NUM_LEVELS(NLVL)
  ) dut (
    .Clk(clk), .Reset_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int rr_cycles = 0;

  always @(negedge clk) if (bus.RoundReset) rr_cycles <= rr_cycles + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- game model ----------------
  state_t m_state;
  int m_secs, m_frames, m_hold, m_lives, m_level, m_win, m_rr;

  function automatic int limit(input int d);
    int l;
    l = RSECS - 5 * d;
    return (l < 10) ? 10 : l;
  endfunction

  function automatic void m_reset();
    m_state = TITLE; m_frames = 0; m_hold = 0;
    m_lives = LIVES0; m_level = 0; m_win = 0; m_secs = 0;
  endfunction

  function automatic void m_enter(input state_t s);
    m_state  = s;
    m_frames = 0;
    if (s == READY) begin m_secs = RDY; m_rr++; end
    if (s == PLAY) m_secs = limit(int'(bus.Difficulty));
    if (s == CAUGHT || s == LEVEL_UP) m_hold = HOLD;
  endfunction

  function automatic void m_frame();
    if (m_state == TITLE || m_state == GAME_OVER) return;
    m_frames++;
    if (m_frames < FPS) return;
    m_frames = 0;
    case (m_state)
      READY: if (m_secs == 0) m_enter(PLAY); else m_secs--;
      PLAY: begin
        m_secs--;
        if (m_secs == 0) begin
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          m_enter(CAUGHT);
        end
      end
      CAUGHT: begin
        m_hold--;
        if (m_hold == 0) m_enter(m_lives > 0 ? READY : GAME_OVER);
      end
      LEVEL_UP: begin
        m_hold--;
        if (m_hold == 0) begin
          if (m_level == NLVL - 1) begin m_win = 1; m_enter(GAME_OVER); end
          else begin m_level++; m_enter(READY); end
        end
      end
      default: ;
    endcase
  endfunction

  function automatic void m_continue();
    if (m_state == TITLE) begin
      m_lives = LIVES0; m_level = 0; m_win = 0;
      m_enter(READY);
    end else if (m_state == GAME_OVER) begin
      m_enter(TITLE);
    end
  endfunction

  function automatic void m_event(input bit caught, input bit escaped);
    if (m_state != PLAY) return;
    if (caught) begin
      m_lives = (m_lives > 0) ? m_lives - 1 : 0;
      m_enter(CAUGHT);
    end else if (escaped) begin
      m_enter(LEVEL_UP);
    end
  endfunction

  task automatic check_all(input string tag);
    int es;
    es = (m_state == TITLE) ? limit(int'(bus.Difficulty)) : m_secs;
    chk({tag, "/state"},  32'(bus.State),      32'(m_state));
    chk({tag, "/gen"},    32'(bus.GameEnable), 32'(m_state == PLAY));
    chk({tag, "/text"},   32'(bus.ShowText),   32'(m_state != PLAY));
    chk({tag, "/win"},    32'(bus.Win),        32'(m_win));
    chk({tag, "/tens"},   32'(bus.SecsTens),   32'(es / 10));
    chk({tag, "/ones"},   32'(bus.SecsOnes),   32'(es % 10));
    chk({tag, "/lives"},  32'(bus.Lives),      32'(m_lives));
    chk({tag, "/level"},  32'(bus.Level),      32'(m_level));
    chk({tag, "/map"},    32'(bus.Map),        32'(m_level));
    chk({tag, "/rr_now"}, 32'(bus.RoundReset), 32'd0);
    chk({tag, "/rr_cnt"}, 32'(rr_cycles),      32'(m_rr));
  endtask

  // ---------------- stimulus ----------------
  task automatic frame_fall();
    @(negedge clk); bus.FrameSync = 1'b0;
    repeat (4) @(negedge clk);
    bus.FrameSync = 1'b1;
    repeat (3) @(negedge clk);
    m_frame();
  endtask

  task automatic frames(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      frame_fall();
      check_all(tag);
    end
  endtask

  task automatic continue_key();
    @(negedge clk); bus.Continue = 1'b1;
    repeat (4) @(negedge clk);
    bus.Continue = 1'b0;
    repeat (3) @(negedge clk);
    m_continue();
  endtask

  task automatic event_pulse(input bit caught, input bit escaped);
    @(negedge clk); bus.PlayerCaught = caught; bus.PlayerEscaped = escaped;
    @(negedge clk); bus.PlayerCaught = 1'b0; bus.PlayerEscaped = 1'b0;
    @(negedge clk);
    m_event(caught, escaped);
  endtask

  task automatic cont_latency();
    @(negedge clk); bus.Continue = 1'b1;
    repeat (2) @(negedge clk);
    chk("cont_lat_2cyc", 32'(bus.State), 32'(TITLE));
    @(negedge clk);
    chk("cont_lat_3cyc", 32'(bus.State), 32'(READY));
    chk("rr_first_cycle", 32'(bus.RoundReset), 32'd1);
    @(negedge clk);
    chk("rr_second_cycle", 32'(bus.RoundReset), 32'd0);
    bus.Continue = 1'b0;
    repeat (3) @(negedge clk);
    m_continue();
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    bus.FrameSync = 1'b1; bus.Continue = 1'b0; bus.Difficulty = 2'd0;
    bus.PlayerCaught = 1'b0; bus.PlayerEscaped = 1'b0;
    m_reset(); m_rr = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_all("reset");

    // Start, countdown, play entry
    cont_latency();
    check_all("ready_entry");
    frames(11, "ready_cd");
    frames(1, "play_entry");
    chk("play_entry_tens", 32'(bus.SecsTens), 32'd1);
    chk("play_entry_ones", 32'(bus.SecsOnes), 32'd2);

    // Timeout
    frames(48, "timeout");
    chk("timeout_state", 32'(bus.State), 32'(CAUGHT));
    chk("timeout_lives", 32'(bus.Lives), 32'd1);
    frames(4, "caught_hold");
    chk("hold_to_ready", 32'(bus.State), 32'(READY));

    // Simultaneous caught + escaped, last life
    frames(12, "ready2");
    event_pulse(1'b1, 1'b1);
    check_all("both_events");
    chk("both_state", 32'(bus.State), 32'(CAUGHT));
    chk("both_level", 32'(bus.Level), 32'd0);
    frames(4, "last_life");
    chk("go_lose_state", 32'(bus.State), 32'(GAME_OVER));
    chk("go_lose_win", 32'(bus.Win), 32'd0);
    event_pulse(1'b1, 1'b0);
    check_all("caught_ignored");
    continue_key();
    check_all("to_title");

    // Escape through both levels
    continue_key();
    frames(12, "lvl0_ready");
    event_pulse(1'b0, 1'b1);
    check_all("escape0");
    chk("escape0_state", 32'(bus.State), 32'(LEVEL_UP));
    frames(4, "lvl_up0");
    chk("lvl1_map", 32'(bus.Map), 32'd1);
    frames(12, "lvl1_ready");
    event_pulse(1'b0, 1'b1);
    frames(4, "lvl_up1");
    chk("go_win_state", 32'(bus.State), 32'(GAME_OVER));
    chk("go_win_win", 32'(bus.Win), 32'd1);
    continue_key();
    check_all("title_again");

    // Difficulty sampling
    bus.Difficulty = 2'd3;
    continue_key();
    frames(12, "diff3");
    chk("diff3_tens", 32'(bus.SecsTens), 32'd1);
    chk("diff3_ones", 32'(bus.SecsOnes), 32'd0);
    bus.Difficulty = 2'd0;
    frames(8, "diff_change");
    chk("diff_change_ones", 32'(bus.SecsOnes), 32'd8);

    // Reset in the middle of PLAY
    @(negedge clk); rst_n = 1'b0;
    #1;
    m_reset();
    check_all("in_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_all("after_reset");

    // Randomized play
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      frame_fall();
      else if (r < 78) continue_key();
      else if (r < 86) event_pulse(1'b1, 1'b0);
      else if (r < 92) event_pulse(1'b0, 1'b1);
      else if (r < 95) event_pulse(1'b1, 1'b1);
      else begin
        bus.Difficulty = 2'($urandom_range(0, 3));
        repeat (2) @(negedge clk);
      end
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
